// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary latches: holding-state encoding and
// the instruction NOP used as the default bubble payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } pipe_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/reg_en_w.sv
// WIDTH-bit enable register with synchronous active-high clear to RESET_VALUE.
module reg_en_w #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline boundary latch with valid/ready handshake, flush-to-bubble and a
// 2-entry skid buffer. Optional stall counter: define PIPE_SKID_STALL_CNT_EN.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid=0, in_ready=1
// ST_ONE   | main holds a payload, skid free, in_ready=1
// ST_TWO   | main and skid both hold payloads, in_ready=0
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = WIDTH'(NOP_INSN),
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             main_valid;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] skid_q;

  // in_ready comes straight off a state flop, so it never sees out_ready.
  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];
  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Flush overwrites both entries with the bubble payload.
  assign main_d = flush ? FLUSH_VALUE : (main_from_skid ? skid_q : in_data);
  assign skid_d = flush ? FLUSH_VALUE : in_data;

  reg_en_w #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk (clk),
    .clr (clr),
    .en  (main_en | flush),
    .d   (main_d),
    .q   (out_data)
  );

  reg_en_w #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk (clk),
    .clr (clr),
    .en  (skid_en | flush),
    .d   (skid_d),
    .q   (skid_q)
  );

`ifdef PIPE_SKID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised plus directed bench for pipe_skid_reg; accepted payloads go into
// a scoreboard queue and a negedge monitor checks everything the DUT presents.
module tb_pipe_skid_reg;

  localparam logic [31:0] RST_V = 32'h1111_1111;
  localparam logic [31:0] FLS_V = 32'h0000_0000;
  localparam int          CW    = 4;

  logic        clk;
  logic        clr;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  pipe_skid_reg #(
    .WIDTH       (32),
    .RESET_VALUE (RST_V),
    .FLUSH_VALUE (FLS_V),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          occ = 0;
  logic        pend_push = 1'b0;
  logic [31:0] pend_data = '0;
  logic        mon_en = 1'b0;
  logic        idle_known = 1'b1;
  logic [31:0] idle_val = RST_V;
  int          stall_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stage is a queue of at most two payloads. Accept when it
  // holds fewer than two; clr/flush empty it and swallow that cycle's input.
  task automatic step(input logic c, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    logic in_fire_m;
    logic out_fire_m;
    @(posedge clk);
    #1;
    if (pend_push) exp_q.push_back(pend_data);
    clr       = c;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    in_fire_m  = iv && (occ < 2) && !c && !f;
    out_fire_m = (occ > 0) && ordy;
    pend_push  = in_fire_m;
    pend_data  = d;
    if (c || f) occ = 0;
    else occ = occ - int'(out_fire_m) + int'(in_fire_m);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      if (exp_q.size() == 0 && idle_known) check("idle_data", out_data, idle_val);
      if (out_valid && out_ready && !clr && exp_q.size() > 0) begin
        check("out_data", out_data, exp_q.pop_front());
      end
`ifdef PIPE_SKID_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
      if (clr) stall_m = 0;
      else if (exp_q.size() > 0 && !out_ready && !flush && stall_m < (2**CW - 1)) stall_m++;
`endif
      if (clr) begin
        exp_q.delete();
        idle_known = 1'b1;
        idle_val   = RST_V;
      end else if (flush) begin
        exp_q.delete();
        idle_known = 1'b1;
        idle_val   = FLS_V;
      end else if (pend_push) begin
        idle_known = 1'b0;
      end
    end
  end

  initial begin
    clk       = 1'b0;
    clr       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;

    // reset held two cycles with a payload offered
    step(1, 0, 1, 32'hDEAD_BEEF, 0);
    mon_en = 1'b1;
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);

    // streaming
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 32'(i), 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // backpressure: A, B, then C refused while full
    step(0, 0, 1, 32'hAAAA_0001, 0);
    step(0, 0, 1, 32'hBBBB_0002, 0);
    step(0, 0, 1, 32'hCCCC_0003, 0);
    step(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1);

    // flush while full with C offered
    step(0, 0, 1, 32'hAAAA_0011, 0);
    step(0, 0, 1, 32'hBBBB_0012, 0);
    step(0, 1, 1, 32'hCCCC_0013, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // clr beats flush
    step(0, 0, 1, 32'hAAAA_0021, 0);
    step(1, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
           ($urandom_range(9) < 7), $urandom, ($urandom_range(9) < 6));
    end
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);

`ifdef PIPE_SKID_STALL_CNT_EN
    step(0, 0, 1, 32'h5555_0031, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
`endif

    step(0, 0, 0, 32'h0, 1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
